// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: walks a PC through a combinational instruction
// memory, delivering one registered word per unstalled cycle.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | presenting pc_q to memory, delivering words
// HALT   | all-zero word fetched, pc_q parked on it
// ERROR  | misaligned or out-of-range PC, captured in err_pc_o
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES    = 16384,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] start_pc_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic [1:0]  state_o,
  output logic [31:0] err_pc_o,
  output logic [15:0] fetch_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [15:0] count_q, count_d;
  logic        pc_bad;

  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      err_pc_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      err_pc_q   <= err_pc_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    err_pc_d   = err_pc_q;
    count_d    = count_q;
    case (state_q)
      S_FETCH: begin
        // Redirect wins over stall and start; the word read this cycle is dropped.
        if (branch_taken_i) begin
          pc_d    = branch_target_i;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          if (pc_bad) begin
            err_pc_d = pc_q;
            valid_d  = 1'b0;
            state_d  = S_ERROR;
          end else if (HALT_ON_ZERO && (imem_data_i == 32'd0)) begin
            valid_d = 1'b0;
            state_d = S_HALT;
          end else begin
            instr_d    = imem_data_i;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
            count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          end
        end
      end
      default: begin
        if (start_i) begin
          pc_d    = start_pc_i;
          valid_d = 1'b0;
          count_d = '0;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign state_o       = state_q;
  assign err_pc_o      = err_pc_q;
  assign fetch_count_o = count_q;

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter: MEM_BYTES, default 16384, instruction memory size in bytes.
REQ-002 Parameter: HALT_ON_ZERO, default 1, halts fetch when an all-zero word is fetched.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse that begins fetching at start_pc.
REQ-006 Port: start_pc  input  32  byte address of the first instruction.
REQ-007 Port: stall  input  1  pipeline hold request from downstream.
REQ-008 Port: branch_taken  input  1  one-cycle redirect request.
REQ-009 Port: branch_target  input  32  byte address used on redirect.
REQ-010 Port: imem_addr  output  32  byte address driven to the combinational instruction memory.
REQ-011 Port: imem_data  input  32  big-endian word returned by memory for imem_addr in the same cycle.
REQ-012 Port: instr  output  32  registered fetched instruction.
REQ-013 Port: instr_pc  output  32  address of instr.
REQ-014 Port: instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-015 Port: state  output  2  IDLE=0, FETCH=1, HALT=2, ERROR=3.
REQ-016 Port: err_pc  output  32  PC that caused entry to ERROR.
REQ-017 Port: fetch_count  output  16  saturating count of instructions delivered.

Function
REQ-018 The block SHALL keep an internal register pc_q and drive imem_addr = pc_q combinationally in every state.
REQ-019 In IDLE, HALT or ERROR, start=1 SHALL load pc_q<=start_pc, clear instr_valid, clear fetch_count, and enter FETCH on the next edge.
REQ-020 In FETCH, the legality check SHALL fail if pc_q[1:0]!=0 or pc_q>MEM_BYTES-4 (unsigned).
REQ-021 In FETCH, with branch_taken=1, the block SHALL set pc_q<=branch_target and instr_valid<=0, regardless of stall, and stay in FETCH; the word on imem_data that cycle SHALL be discarded.
REQ-022 In FETCH, with branch_taken=0 and stall=1, the block SHALL hold pc_q, instr, instr_pc, instr_valid and fetch_count.
REQ-023 In FETCH, with branch_taken=0, stall=0 and a failed check, the block SHALL set err_pc<=pc_q and instr_valid<=0, and enter ERROR.
REQ-024 In FETCH, with branch_taken=0, stall=0, a passing check, HALT_ON_ZERO=1 and imem_data==0, the block SHALL set instr_valid<=0 and enter HALT, with pc_q held at the zero word's address.
REQ-025 Otherwise in FETCH, with branch_taken=0 and stall=0, the block SHALL set instr<=imem_data, instr_pc<=pc_q, instr_valid<=1, pc_q<=pc_q+4 and fetch_count<=fetch_count+1, saturating at 16'hFFFF.
REQ-026 Latency: one cycle from pc_q presented to instr_valid=1; one instruction per unstalled cycle.
REQ-027 Simultaneous start and branch_taken in FETCH: start SHALL be ignored and branch_taken applied.
REQ-028 branch_taken, stall and start SHALL be ignored in IDLE, HALT and ERROR, except start as in REQ-019.
REQ-029 pc_q+4 SHALL wrap modulo 2^32; out-of-range PCs SHALL be caught by REQ-020 before any fetch.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=IDLE, pc_q=0, instr=0, instr_pc=0, instr_valid=0, err_pc=0 and fetch_count=0, overriding all other inputs, including mid-FETCH.
REQ-031 After reset is released, the block SHALL stay in IDLE until start.

Verification
REQ-032 Sequential fetch: memory preloaded with 0x48080000..0x480F001C at 100..128 and zero beyond, start_pc=100 -> eight instr_valid cycles with instr_pc=100..128, then HALT with pc_q=132 and fetch_count=8.
REQ-033 Branch redirect: start_pc=500, branch_taken pulsed with target 500 in the cycle pc_q=520 -> word at 520 not delivered, next delivered instr_pc=500.
REQ-034 Stall: start_pc=200, stall high 3 cycles after the first delivery -> instr_pc stays 200 for 4 cycles, then continues at 204; fetch_count=6 at HALT on 224.
REQ-035 Errors: start_pc=102 -> ERROR next cycle with err_pc=102 and no delivery; start_pc=16380 -> one delivery, then ERROR with err_pc=16384.
REQ-036 Reset mid-operation: reset asserted while delivering at 612 -> next cycle state=IDLE with all outputs zero; start_pc=600 then refetches from 600.
